// File: rtl/alu_issue.sv
// alu_issue: decode-and-issue stage in front of the 3-bit-opcode ALU.
// It decodes RV32I OP/OP-IMM instructions into ALU opcode, operands and
// writeback control, and buffers them in a two-entry skid buffer (M drives
// the outputs, S catches the entry that arrives while M is stalled).
// It also keeps a saturating count of illegal instructions issued.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and its payload until that transfer.
// in_ready is a register (= !S valid), so it has no combinational path from
// out_ready. out_* stay stable while out_valid=1 and out_ready=0.
module alu_issue #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_rs1_val,
    input  logic [31:0]      in_rs2_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_a,
    output logic [31:0]      out_b,
    output logic [2:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic             out_we,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLL  = 3'b101;
    localparam logic [2:0] ALU_SRL  = 3'b110;
    localparam logic [2:0] ALU_SLTU = 3'b111;

    localparam logic [6:0] MAJ_OP     = 7'b0110011;
    localparam logic [6:0] MAJ_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    // Entry layout: {a, b, opcode, rd, we, illegal}
    localparam int ENTRY_W = 32 + 32 + 3 + 5 + 1 + 1;

    logic [6:0]  major;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        is_op;
    logic        is_imm;
    logic        dec_legal;
    logic [2:0]  dec_alu_op;
    logic [31:0] dec_b_raw;
    logic [ENTRY_W-1:0] dec_entry;

    logic [ENTRY_W-1:0] m_entry;
    logic [ENTRY_W-1:0] s_entry;
    logic               m_valid;
    logic               s_valid;
    logic               in_fire;
    logic               out_fire;
    logic               m_free;

    assign major  = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];
    assign is_op  = (major == MAJ_OP);
    assign is_imm = (major == MAJ_OP_IMM);

    // Decode funct3/funct7 into an ALU opcode and a legality flag.
    always_comb begin
        dec_legal  = 1'b0;
        dec_alu_op = ALU_ADD;
        if (is_op || is_imm) begin
            case (funct3)
                3'b000: begin
                    // OP-IMM has no SUB form; its funct7 bits are immediate.
                    if (is_imm || funct7 == F7_ZERO) begin
                        dec_legal  = 1'b1;
                        dec_alu_op = ALU_ADD;
                    end else if (funct7 == F7_ALT) begin
                        dec_legal  = 1'b1;
                        dec_alu_op = ALU_SUB;
                    end
                end
                3'b001: begin
                    dec_legal  = (funct7 == F7_ZERO);
                    dec_alu_op = ALU_SLL;
                end
                3'b101: begin
                    // Arithmetic right shift is not supported by the ALU.
                    dec_legal  = (funct7 == F7_ZERO);
                    dec_alu_op = ALU_SRL;
                end
                3'b011: begin
                    dec_legal  = 1'b1;
                    dec_alu_op = ALU_SLTU;
                end
                3'b100: begin
                    dec_legal  = 1'b1;
                    dec_alu_op = ALU_XOR;
                end
                3'b110: begin
                    dec_legal  = 1'b1;
                    dec_alu_op = ALU_OR;
                end
                3'b111: begin
                    dec_legal  = 1'b1;
                    dec_alu_op = ALU_AND;
                end
                default: begin
                    // Signed compare (SLT) has no ALU opcode.
                    dec_legal  = 1'b0;
                    dec_alu_op = ALU_ADD;
                end
            endcase
        end
    end

    // Select operand B: register, shift amount, or sign-extended immediate.
    always_comb begin
        dec_b_raw = in_rs2_val;
        if (is_imm) begin
            if (funct3 == 3'b001 || funct3 == 3'b101)
                dec_b_raw = {27'd0, in_inst[24:20]};
            else
                dec_b_raw = {{20{in_inst[31]}}, in_inst[31:20]};
        end
    end

    // Assemble the buffered entry; illegal entries carry zero operands.
    always_comb begin
        if (dec_legal)
            dec_entry = {in_rs1_val, dec_b_raw, dec_alu_op, in_inst[11:7],
                         (in_inst[11:7] != 5'd0), 1'b0};
        else
            dec_entry = {32'd0, 32'd0, ALU_ADD, in_inst[11:7], 1'b0, 1'b1};
    end

    assign in_ready = !s_valid;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = m_valid && out_ready;
    assign m_free   = !m_valid || out_ready;

    // Skid buffer: M refills from S first (FIFO order), else from the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_entry <= '0;
            s_entry <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (m_free) begin
            if (s_valid) begin
                m_entry <= s_entry;
                m_valid <= 1'b1;
                s_valid <= 1'b0;
            end else if (in_fire) begin
                m_entry <= dec_entry;
                m_valid <= 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (in_fire) begin
            s_entry <= dec_entry;
            s_valid <= 1'b1;
        end
    end

    // Count illegal entries leaving the stage, saturating; flush does not clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_count <= '0;
        else if (out_fire && m_entry[0] && (illegal_count != {CNT_W{1'b1}}))
            illegal_count <= illegal_count + 1'b1;
    end

    assign out_valid   = m_valid;
    assign out_a       = m_entry[73:42];
    assign out_b       = m_entry[41:10];
    assign out_opcode  = m_entry[9:7];
    assign out_rd      = m_entry[6:2];
    assign out_we      = m_entry[1];
    assign out_illegal = m_entry[0];

endmodule
